// File: rtl/emmc_traffic_gen_pkg.sv
// Shared types and pattern rules for the eMMC traffic generator/checker.
package emmc_tg_p;

  typedef enum logic [1:0] {
    TG_INC   = 2'd0,
    TG_LFSR  = 2'd1,
    TG_CONST = 2'd2,
    TG_WALK  = 2'd3
  } tg_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RUN,
    ST_RD_REQ,
    ST_RD_RUN,
    ST_DONE
  } tg_state_e;

  localparam logic [7:0] TG_LFSR_MASK = 8'hB8;

  // LFSR cannot start from 0 and the walking bit always starts at bit 0.
  function automatic logic [7:0] tg_start(input tg_mode_e mode, input logic [7:0] val);
    logic [7:0] res;
    res = val;
    if (mode == TG_LFSR && val == 8'h00) res = 8'h01;
    if (mode == TG_WALK) res = 8'h01;
    return res;
  endfunction

  function automatic logic [7:0] tg_next(input tg_mode_e mode, input logic [7:0] cur);
    logic [7:0] res;
    case (mode)
      TG_INC:  res = cur + 8'd1;
      TG_LFSR: res = cur[0] ? ((cur >> 1) ^ TG_LFSR_MASK) : (cur >> 1);
      TG_WALK: res = {cur[6:0], cur[7]};
      default: res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/emmc_traffic_gen_pattern.sv
// 8-bit pattern register: load(value, mode) and advance by the selected rule.
module emmc_tg_pattern
  import emmc_tg_p::*;
(
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       load_i,
  input  logic       adv_i,
  input  logic [1:0] mode_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] pat_o
);

  tg_mode_e mode;
  assign mode = tg_mode_e'(mode_i);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      pat_o <= '0;
    end else if (load_i) begin
      pat_o <= tg_start(mode, load_val_i);
    end else if (adv_i) begin
      pat_o <= tg_next(mode, pat_o);
    end
  end

endmodule

// File: rtl/emmc_traffic_gen.sv
// Write/read-back traffic generator for emmc_sm; the read checker is built
// only when EMMC_TG_CHECK_EN is defined.
module emmc_traffic_gen
  import emmc_tg_p::*;
#(
  parameter int         BLK_CNT_W = 8,
  parameter int         BLK_BYTES = 512,
  parameter int         PASSES    = 0,
  parameter logic [7:0] SEED      = 8'h01
) (
  input  logic                                   clk_i,
  input  logic                                   arst_ni,
  input  logic                                   run_i,
  input  logic [1:0]                             mode_i,
  input  logic [BLK_CNT_W-1:0]                   blk_cnt_i,
  input  logic                                   ready_i,
  input  logic                                   dvalid_i,
  input  logic [7:0]                             dat_i,
  output logic                                   start_o,
  output logic                                   we_o,
  output logic [7:0]                             dat_o,
  output logic [BLK_CNT_W-1:0]                   blk_cnt_o,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic [15:0]                            pass_cnt_o,
  output logic [15:0]                            err_cnt_o,
  output logic [BLK_CNT_W+$clog2(BLK_BYTES)-1:0] first_err_o,
  output logic                                   len_err_o
);

  localparam int OFF_W = $clog2(BLK_BYTES);
  localparam int IDX_W = BLK_CNT_W + OFF_W;
  localparam int BC_W  = IDX_W + 1;

  tg_state_e        state_q, state_d;
  tg_mode_e         mode_q;
  logic [BC_W-1:0]  byte_cnt_q, byte_inc, exp_len;
  logic [15:0]      pass_nxt;
  logic             in_run, run_start;
  logic             pat_load, pat_adv;
  logic [7:0]       pat_val;
  tg_mode_e         pat_mode;

  assign in_run    = (state_q == ST_WR_RUN) || (state_q == ST_RD_RUN);
  assign run_start = (state_q == ST_IDLE) && (state_d == ST_WR_REQ);
  assign byte_inc  = byte_cnt_q + {{(BC_W-1){1'b0}}, dvalid_i};
  assign exp_len   = {1'b0, blk_cnt_o, {OFF_W{1'b0}}};
  assign pass_nxt  = pass_cnt_o + 16'd1;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pat_load = 1'b0;
    pat_adv  = 1'b0;
    pat_val  = SEED;
    pat_mode = mode_q;
    case (state_q)
      ST_IDLE: if (run_i && ready_i) begin
        state_d  = ST_WR_REQ;
        pat_load = 1'b1;
        pat_mode = tg_mode_e'(mode_i);
      end
      ST_WR_REQ: if (!ready_i) state_d = ST_WR_RUN;
      ST_WR_RUN: begin
        pat_adv = dvalid_i;
        if (ready_i) begin
          state_d  = ST_RD_REQ;
          pat_load = 1'b1;
          pat_val  = SEED + pass_cnt_o[7:0];
        end
      end
      ST_RD_REQ: if (!ready_i) state_d = ST_RD_RUN;
      ST_RD_RUN: begin
        pat_adv = dvalid_i;
        if (ready_i) begin
          if (PASSES != 0 && pass_nxt == 16'(PASSES)) begin
            state_d = ST_DONE;
          end else if (!run_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_WR_REQ;
            pat_load = 1'b1;
            pat_val  = SEED + pass_nxt[7:0];
          end
        end
      end
      ST_DONE: if (!run_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      mode_q     <= TG_INC;
      byte_cnt_q <= '0;
      start_o    <= 1'b0;
      we_o       <= 1'b0;
      blk_cnt_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_cnt_o <= '0;
      len_err_o  <= 1'b0;
    end else begin
      start_o <= (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
      we_o    <= (state_d == ST_WR_REQ) || (state_d == ST_WR_RUN);
      busy_o  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_o  <= (state_d == ST_DONE);
      if (state_q == ST_WR_REQ || state_q == ST_RD_REQ) begin
        byte_cnt_q <= '0;
      end else if (in_run && dvalid_i) begin
        byte_cnt_q <= byte_inc;
      end
      if (run_start) begin
        mode_q     <= tg_mode_e'(mode_i);
        blk_cnt_o  <= (blk_cnt_i == '0) ? {{(BLK_CNT_W-1){1'b0}}, 1'b1} : blk_cnt_i;
        pass_cnt_o <= '0;
        len_err_o  <= 1'b0;
      end else begin
        if (in_run && ready_i && byte_inc != exp_len) len_err_o <= 1'b1;
        if (state_q == ST_RD_RUN && ready_i) pass_cnt_o <= pass_nxt;
      end
    end
  end

`ifdef EMMC_TG_CHECK_EN
  logic rd_bad;
  assign rd_bad = (state_q == ST_RD_RUN) && dvalid_i && (dat_i != dat_o);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      err_cnt_o   <= '0;
      first_err_o <= '0;
    end else if (run_start) begin
      err_cnt_o   <= '0;
      first_err_o <= '0;
    end else if (rd_bad) begin
      if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
      if (err_cnt_o == 16'd0)    first_err_o <= byte_cnt_q[IDX_W-1:0];
    end
  end
`else
  logic unused_dat;
  assign unused_dat  = ^dat_i;
  assign err_cnt_o   = '0;
  assign first_err_o = '0;
`endif

  emmc_tg_pattern u_pattern (
    .clk_i      (clk_i),
    .arst_ni    (arst_ni),
    .load_i     (pat_load),
    .adv_i      (pat_adv),
    .mode_i     (pat_mode),
    .load_val_i (pat_val),
    .pat_o      (dat_o)
  );

endmodule

// File: tb/tb_emmc_traffic_gen.sv
// Self-checking bench for emmc_traffic_gen with a transaction-level emmc_sm model.
module tb_emmc_traffic_gen;

  localparam int         W  = 8;
  localparam int         BB = 512;
  localparam int         NP = 3;
  localparam logic [7:0] SD = 8'h00;
  localparam int         IW = W + $clog2(BB);

  logic          clk_i = 1'b0;
  logic          arst_ni = 1'b0;
  logic          run_i = 1'b0;
  logic [1:0]    mode_i = '0;
  logic [W-1:0]  blk_cnt_i = '0;
  logic          ready_i = 1'b1;
  logic          dvalid_i = 1'b0;
  logic [7:0]    dat_i = '0;
  logic          start_o, we_o, busy_o, done_o, len_err_o;
  logic [7:0]    dat_o;
  logic [W-1:0]  blk_cnt_o;
  logic [15:0]   pass_cnt_o, err_cnt_o;
  logic [IW-1:0] first_err_o;

  emmc_traffic_gen #(
    .BLK_CNT_W (W),
    .BLK_BYTES (BB),
    .PASSES    (NP),
    .SEED      (SD)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .run_i       (run_i),
    .mode_i      (mode_i),
    .blk_cnt_i   (blk_cnt_i),
    .ready_i     (ready_i),
    .dvalid_i    (dvalid_i),
    .dat_i       (dat_i),
    .start_o     (start_o),
    .we_o        (we_o),
    .dat_o       (dat_o),
    .blk_cnt_o   (blk_cnt_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_cnt_o  (pass_cnt_o),
    .err_cnt_o   (err_cnt_o),
    .first_err_o (first_err_o),
    .len_err_o   (len_err_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Expected outputs, maintained at transaction level by the emmc_sm model.
  bit            e_start, e_we, e_busy, e_done, e_len;
  logic [W-1:0]  e_blk;
  logic [15:0]   e_pass, e_err;
  logic [IW-1:0] e_first;
  bit            chk_en = 1'b1;

  logic [7:0] stream [0:4095];
  logic [7:0] obs0   [0:4095];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) if (chk_en) begin
    chk("start_o",     32'(start_o),     32'(e_start));
    chk("we_o",        32'(we_o),        32'(e_we));
    chk("busy_o",      32'(busy_o),      32'(e_busy));
    chk("done_o",      32'(done_o),      32'(e_done));
    chk("len_err_o",   32'(len_err_o),   32'(e_len));
    chk("blk_cnt_o",   32'(blk_cnt_o),   32'(e_blk));
    chk("pass_cnt_o",  32'(pass_cnt_o),  32'(e_pass));
    chk("err_cnt_o",   32'(err_cnt_o),   32'(e_err));
    chk("first_err_o", 32'(first_err_o), 32'(e_first));
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic zero_model();
    e_start = 0; e_we = 0; e_busy = 0; e_done = 0; e_len = 0;
    e_blk = '0; e_pass = '0; e_err = '0; e_first = '0;
  endtask

  // Byte k of a pass as given directly by the pattern rules.
  task automatic build(input logic [1:0] md, input logic [7:0] st, input int n);
    logic [7:0] cur;
    cur = (st == 8'h00) ? 8'h01 : st;
    for (int k = 0; k < n; k++) begin
      case (md)
        2'd0: stream[k] = st + 8'(k);
        2'd1: begin
          stream[k] = cur;
          cur = cur[0] ? ((cur >> 1) ^ 8'hB8) : (cur >> 1);
        end
        2'd2: stream[k] = st;
        default: stream[k] = 8'h01 << (k % 8);
      endcase
    end
  endtask

  task automatic xfer(input bit wr, input int n, input int drop_k, input int rst_k,
                      input bit corrupt, input bit simul, input bit rec, output bit ab);
    bit bad;
    ab = 0;
    repeat ($urandom_range(0, 2)) tick();
    ready_i = 0;
    tick();
    e_start = 0;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 1)) tick();
      bad = 0;
      dvalid_i = 1;
      if (!wr) begin
        dat_i = stream[k];
        if (corrupt && (k == 37 || k == 300)) begin
          dat_i = dat_i ^ 8'($urandom_range(1, 255));
          bad = 1;
        end
      end
      if (simul && k == n - 1) ready_i = 1;
      if (wr) begin
        @(negedge clk_i);
        chk("dat_o", 32'(dat_o), 32'(stream[k]));
        if (rec) obs0[k] = dat_o;
      end
      tick();
      dvalid_i = 0;
`ifdef EMMC_TG_CHECK_EN
      if (bad) begin
        if (e_err == 0) e_first = IW'(k);
        e_err++;
      end
`endif
      if (k == drop_k) run_i = 0;
      if (k == rst_k) begin
        arst_ni = 0;
        run_i = 0;
        ready_i = 1;
        zero_model();
        #1;
        chk("rst_mid_dat_o", 32'(dat_o), 32'h0);
        chk("rst_mid_busy", 32'(busy_o), 32'h0);
        tick();
        arst_ni = 1;
        ab = 1;
        return;
      end
    end
    if (!simul) begin
      repeat ($urandom_range(0, 2)) tick();
      ready_i = 1;
      tick();
    end
    if (n != int'(e_blk) * BB) e_len = 1;
  endtask

  task automatic do_run(input logic [1:0] md, input logic [W-1:0] bc, input int drop_pass,
                        input int short_pass, input int rst_pass, input bit corrupt,
                        input bit simul);
    int nb;
    bit ab;
    logic [7:0] st;
    mode_i = md;
    blk_cnt_i = bc;
    run_i = 1;
    tick();
    zero_model();
    e_busy = 1; e_start = 1; e_we = 1;
    e_blk = (bc == '0) ? W'(1) : bc;
    mode_i = 2'($urandom);
    blk_cnt_i = W'($urandom);
    nb = int'(e_blk) * BB;
    for (int p = 0; p < 16; p++) begin
      st = SD + 8'(p);
      build(md, st, nb);
      xfer(1, (p == short_pass) ? nb - 1 : nb, (p == drop_pass) ? nb / 2 : -1, -1,
           0, simul && p == 0, p == 0, ab);
      e_start = 1; e_we = 0;
      xfer(0, nb, -1, (p == rst_pass) ? 100 : -1, corrupt && p == 0, simul && p == 1, 0, ab);
      if (ab) return;
      e_pass++;
      if (int'(e_pass) == NP) begin
        e_done = 1; e_busy = 0; e_start = 0; e_we = 0;
        repeat (3) tick();
        run_i = 0;
        tick();
        e_done = 0;
        return;
      end
      if (!run_i) begin
        e_busy = 0; e_start = 0; e_we = 0;
        return;
      end
      e_start = 1; e_we = 1;
    end
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    zero_model();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_dat_o", 32'(dat_o), 32'h0);
    arst_ni = 1;
    tick();

    // INC, zero block count, simultaneous last byte and ready rise.
    do_run(2'd0, '0, -1, -1, -1, 0, 1);
    chk("inc_b255", 32'(obs0[255]), 32'hFF);
    chk("inc_b256", 32'(obs0[256]), 32'h00);
    chk("inc_b257", 32'(obs0[257]), 32'h01);
    chk("inc_pass", 32'(pass_cnt_o), 32'd3);
    chk("inc_len",  32'(len_err_o), 32'd0);

    // LFSR with corrupted reads and a short write in pass 1.
    do_run(2'd1, W'(1), -1, 1, -1, 1, 0);
    chk("lfsr_b0", 32'(obs0[0]), 32'h01);
    chk("lfsr_b1", 32'(obs0[1]), 32'hB8);
    chk("lfsr_b2", 32'(obs0[2]), 32'h5C);
    chk("lfsr_b3", 32'(obs0[3]), 32'h2E);
    chk("lfsr_len", 32'(len_err_o), 32'd1);
`ifdef EMMC_TG_CHECK_EN
    chk("lfsr_err",   32'(err_cnt_o),   32'd2);
    chk("lfsr_first", 32'(first_err_o), 32'd37);
`else
    chk("lfsr_err",   32'(err_cnt_o),   32'd0);
`endif

    // WALK, two blocks, run_i dropped mid-write of the second pass.
    do_run(2'd3, W'(2), 1, -1, -1, 0, 0);
    chk("walk_b7",   32'(obs0[7]), 32'h80);
    chk("walk_b8",   32'(obs0[8]), 32'h01);
    chk("walk_pass", 32'(pass_cnt_o), 32'd2);
    chk("walk_done", 32'(done_o), 32'd0);
    chk("walk_blk",  32'(blk_cnt_o), 32'd2);

    // CONST, reset during the first read phase.
    do_run(2'd2, W'(1), -1, -1, 0, 0, 0);
    chk("const_rst_pass", 32'(pass_cnt_o), 32'd0);

    // Random mode after reset must restart from SEED.
    do_run(2'($urandom), W'(1), -1, -1, -1, 0, 0);
    chk("rand_pass", 32'(pass_cnt_o), 32'd3);

    repeat (3) tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
